// File: rtl/filter_ewma_sched_if.sv
// filter_ewma_sched_if: sample/alpha inputs and filtered outputs of the shared EWMA filter
interface filter_ewma_sched_if #(
  parameter int DATA_BITS = 12,
  parameter int VOICES = 4
);
  logic sample_tick;
  logic [VOICES*DATA_BITS-1:0] din_bus;
  logic [VOICES*9-1:0] alpha_bus;
  logic [VOICES*DATA_BITS-1:0] dout_bus;
  logic dout_valid;
  logic busy;
  logic overrun;
  modport master (
    output sample_tick, din_bus, alpha_bus,
    input dout_bus, dout_valid, busy, overrun
  );
  modport slave (
    input sample_tick, din_bus, alpha_bus,
    output dout_bus, dout_valid, busy, overrun
  );
endinterface

// File: rtl/filter_ewma_sched.sv
// filter_ewma_sched: time-multiplexed EWMA low-pass filter, one voice per clock through a shared datapath
module filter_ewma_sched #(
  parameter int DATA_BITS = 12,
  parameter int VOICES = 4
) (
  input logic clk,
  input logic rst,
  filter_ewma_sched_if.slave bus
);
  localparam int IW = $clog2(VOICES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] st_q [VOICES];
  logic [DATA_BITS-1:0] st_d [VOICES];
  logic [DATA_BITS-1:0] snap_din_q [VOICES];
  logic [DATA_BITS-1:0] snap_din_d [VOICES];
  logic [8:0] snap_alpha_q [VOICES];
  logic [8:0] snap_alpha_d [VOICES];
  logic [VOICES*DATA_BITS-1:0] dout_q, dout_d;
  logic valid_q, valid_d;
  logic overrun_q, overrun_d;
  logic [DATA_BITS-1:0] cur_st, cur_din, st_new;
  logic [8:0] cur_alpha;
  logic [DATA_BITS:0] diff;
  logic [DATA_BITS+9:0] prod;
  logic last;
  logic unused_prod_bits;
  // Sign-extended operands make the truncated unsigned product equal the signed one;
  // bits [DATA_BITS+7:8] are the low bits of prod >>> 8, all the wrapped sum needs.
  always_comb begin
    cur_st = st_q[idx_q];
    cur_din = snap_din_q[idx_q];
    cur_alpha = snap_alpha_q[idx_q];
    diff = {cur_din[DATA_BITS-1], cur_din} - {cur_st[DATA_BITS-1], cur_st};
    prod = {{9{diff[DATA_BITS]}}, diff} * {{(DATA_BITS+1){cur_alpha[8]}}, cur_alpha};
    st_new = prod[DATA_BITS+7:8] + cur_st;
    last = idx_q == IW'(VOICES-1);
  end
  assign unused_prod_bits = ^{prod[7:0], prod[DATA_BITS+9:DATA_BITS+8]};
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    st_d = st_q;
    snap_din_d = snap_din_q;
    snap_alpha_d = snap_alpha_q;
    dout_d = dout_q;
    valid_d = 1'b0;
    overrun_d = overrun_q | (bus.sample_tick & (state_q == RUN));
    if (state_q == IDLE) begin
      if (bus.sample_tick) begin
        state_d = RUN;
        idx_d = '0;
        for (int v = 0; v < VOICES; v++) begin
          snap_din_d[v] = bus.din_bus[v*DATA_BITS +: DATA_BITS];
          snap_alpha_d[v] = bus.alpha_bus[v*9 +: 9];
        end
      end
    end else begin
      st_d[idx_q] = st_new;
      idx_d = last ? '0 : idx_q + IW'(1);
      state_d = last ? IDLE : RUN;
      valid_d = last;
      if (last)
        for (int v = 0; v < VOICES; v++) dout_d[v*DATA_BITS +: DATA_BITS] = st_d[v];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      st_q <= '{default: '0};
      snap_din_q <= '{default: '0};
      snap_alpha_q <= '{default: '0};
      dout_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      st_q <= st_d;
      snap_din_q <= snap_din_d;
      snap_alpha_q <= snap_alpha_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.dout_bus = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy = state_q == RUN;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_filter_ewma_sched.sv
// tb_filter_ewma_sched: directed vectors with hand-computed EWMA outputs for the 4-voice, 12-bit filter
module tb_filter_ewma_sched;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  filter_ewma_sched_if #(.DATA_BITS(12), .VOICES(4)) bus ();
  filter_ewma_sched #(.DATA_BITS(12), .VOICES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] din;
    logic [35:0] alpha;
    logic [47:0] exp;
  } vec_t;
  vec_t tbl [6];
  function automatic logic [47:0] p12(int a, int b, int c, int d);
    logic [11:0] x0, x1, x2, x3;
    x0 = 12'(a); x1 = 12'(b); x2 = 12'(c); x3 = 12'(d);
    return {x3, x2, x1, x0};
  endfunction
  function automatic logic [35:0] pa(int a, int b, int c, int d);
    logic [8:0] x0, x1, x2, x3;
    x0 = 9'(a); x1 = 9'(b); x2 = 9'(c); x3 = 9'(d);
    return {x3, x2, x1, x0};
  endfunction
  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Tick in the current cycle and stop in the cycle where dout_valid is seen (lat = 5 expected).
  task automatic run_pass(output int lat);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    lat = 1;
    while (!bus.dout_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask
  initial begin
    int lat, nvalid;
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    bus.din_bus = '0;
    bus.alpha_bus = '0;
    tbl[0] = '{p12(1000, 0, 0, 0), pa(128, 0, 0, 0), p12(500, 0, 0, 0)};
    tbl[1] = '{p12(1000, 0, 0, 0), pa(128, 0, 0, 0), p12(750, 0, 0, 0)};
    tbl[2] = '{p12(1000, 0, 0, 0), pa(128, 0, 0, 0), p12(875, 0, 0, 0)};
    tbl[3] = '{p12(1000, 0, 0, 0), pa(128, 0, 0, 0), p12(937, 0, 0, 0)};
    tbl[4] = '{p12(1000, 1000, 1000, -1000), pa(0, 255, 0, 128), p12(937, 996, 0, -500)};
    tbl[5] = '{p12(0, 1000, 1000, -1000), pa(128, 255, -128, 128), p12(468, 999, -500, -750)};
    repeat (3) step();
    chk("reset dout", bus.dout_bus, '0);
    chk("reset flags", {45'd0, bus.dout_valid, bus.busy, bus.overrun}, '0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.din_bus = tbl[i].din;
      bus.alpha_bus = tbl[i].alpha;
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      chk($sformatf("vec%0d busy", i), {47'd0, bus.busy}, 48'd1);
      lat = 1;
      while (!bus.dout_valid && lat < 20) begin
        step();
        lat++;
      end
      chk($sformatf("vec%0d latency", i), 48'(lat), 48'd5);
      chk($sformatf("vec%0d dout", i), bus.dout_bus, tbl[i].exp);
      chk($sformatf("vec%0d busy at valid", i), {47'd0, bus.busy}, 48'd0);
      repeat (3) step();
    end
    // Second tick two cycles into the pass must be dropped and flagged.
    bus.din_bus = p12(1000, 0, 0, 0);
    bus.alpha_bus = pa(128, 0, 0, 0);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    bus.sample_tick = 1'b1;
    bus.din_bus = p12(2000, 2000, 2000, 2000);
    step();
    bus.sample_tick = 1'b0;
    nvalid = 0;
    repeat (15) begin
      if (bus.dout_valid) nvalid++;
      step();
    end
    chk("overrun valid count", 48'(nvalid), 48'd1);
    chk("overrun dout", bus.dout_bus, p12(734, 999, -500, -750));
    chk("overrun sticky", {47'd0, bus.overrun}, 48'd1);
    // Reset in cycle 3 of a pass: nothing published, everything cleared.
    bus.din_bus = p12(1000, 1000, 1000, 1000);
    bus.alpha_bus = pa(128, 128, 128, 128);
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvalid = 0;
    repeat (10) begin
      if (bus.dout_valid) nvalid++;
      step();
    end
    chk("midreset valid count", 48'(nvalid), 48'd0);
    chk("midreset dout", bus.dout_bus, '0);
    chk("midreset flags", {45'd0, bus.dout_valid, bus.busy, bus.overrun}, '0);
    rst = 1'b1;
    bus.sample_tick = 1'b1;
    step();
    rst = 1'b0;
    bus.sample_tick = 1'b0;
    step();
    chk("tick with reset dropped", {47'd0, bus.busy}, 48'd0);
    // Snapshot isolation: din changes in cycle 2 of the pass.
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
    step();
    bus.din_bus = p12(2000, 2000, 2000, 2000);
    lat = 2;
    while (!bus.dout_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("snapshot latency", 48'(lat), 48'd5);
    chk("snapshot dout", bus.dout_bus, p12(500, 500, 500, 500));
    step();
    run_pass(lat);
    chk("snapshot next dout", bus.dout_bus, p12(1250, 1250, 1250, 1250));
    // Back-to-back ticks and extreme values on voice 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.din_bus = p12(-2048, 0, 0, 0);
    bus.alpha_bus = pa(255, 0, 0, 0);
    run_pass(lat);
    chk("extreme pass1", bus.dout_bus, p12(-2040, 0, 0, 0));
    run_pass(lat);
    chk("back-to-back latency", 48'(lat), 48'd5);
    chk("extreme pass2", bus.dout_bus, p12(-2048, 0, 0, 0));
    bus.din_bus = p12(2047, 0, 0, 0);
    run_pass(lat);
    chk("extreme pass3 latency", 48'(lat), 48'd5);
    chk("extreme pass3", bus.dout_bus, p12(2031, 0, 0, 0));
    step();
    chk("valid one cycle", {47'd0, bus.dout_valid}, 48'd0);
    chk("dout stable", bus.dout_bus, p12(2031, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
